// File: rtl/buffer_read_scheduler_pkg.sv
// Shared definitions for the buffer read scheduler.
// Holds the FSM state encoding, the buffer geometry (count, occupancy and
// payload field widths) and a helper that clamps an occupancy field to the
// buffer depth.
package buffer_read_scheduler_pkg;

    localparam int NUM_BUF    = 4;
    localparam int OCC_W      = 3;
    localparam int DATA_W     = 2;
    localparam int SEL_W      = $clog2(NUM_BUF);
    // Packed-bus widths: buffer b owns bits [b*FIELD_W +: FIELD_W]
    localparam int OCC_BUS_W  = NUM_BUF * OCC_W;
    localparam int DATA_BUS_W = NUM_BUF * DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SELECT,
        ST_POP,
        ST_SHOW
    } state_e;

    // Occupancy counts above the physical depth are treated as full.
    function automatic logic [OCC_W-1:0] sat_occ(input logic [OCC_W-1:0] occ,
                                                 input logic [OCC_W-1:0] depth);
        return (occ > depth) ? depth : occ;
    endfunction

endpackage

// File: rtl/rr_max_select.sv
// Combinational argmax over the four buffer occupancies.
// Ports:
//   occ_i    - packed occupancies, buffer b at [b*OCC_W +: OCC_W]
//   rr_ptr_i - first buffer considered when several share the maximum
//   valid_o  - at least one buffer is non-empty
//   idx_o    - selected buffer (first max found scanning up from rr_ptr_i)
module rr_max_select
    import buffer_read_scheduler_pkg::*;
(
    input  logic [OCC_BUS_W-1:0] occ_i,
    input  logic [SEL_W-1:0]     rr_ptr_i,
    output logic                 valid_o,
    output logic [SEL_W-1:0]     idx_o
);

    logic [OCC_W-1:0] occ [NUM_BUF];
    logic [OCC_W-1:0] max_v;
    logic [SEL_W-1:0] cand;
    logic             found;

    always_comb begin
        max_v = '0;
        for (int b = 0; b < NUM_BUF; b++) begin
            occ[b] = occ_i[b*OCC_W +: OCC_W];
            if (occ[b] > max_v) max_v = occ[b];
        end
        // Scan upward from the pointer; SEL_W-bit arithmetic wraps mod 4.
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_BUF; k++) begin
            cand = rr_ptr_i + SEL_W'(k);
            if (!found && occ[cand] == max_v) begin
                idx_o = cand;
                found = 1'b1;
            end
        end
    end

    assign valid_o = (max_v != '0);

endmodule

// File: rtl/buffer_read_scheduler.sv
// Paced read scheduler for the four packet buffers.
// Every READ_INTERVAL cycles it picks the fullest non-empty buffer (round-
// robin tie-break), pops its head via a req/ack handshake, latches the
// payload and buffer id, and pulses read_o for SHOW_CYCLES cycles.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - level enable for scheduling
//   occ_i         - four 3-bit occupancies
//   head_data_i   - four 2-bit head payloads
//   pop_ack_i     - buffer side removed head of pop_sel_o
//   pop_req_o     - pop request, held until acked
//   pop_sel_o     - buffer being popped
//   read_o        - read-activity indicator
//   disp_o        - id of last buffer read
//   data_o        - payload of last packet read
//   read_cnt_o    - completed pop count (wraps)
module buffer_read_scheduler
    import buffer_read_scheduler_pkg::*;
#(
    parameter int READ_INTERVAL = 150000000,
    parameter int SHOW_CYCLES   = 25000000,
    parameter int DEPTH         = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [OCC_BUS_W-1:0]  occ_i,
    input  logic [DATA_BUS_W-1:0] head_data_i,
    input  logic                  pop_ack_i,
    output logic                  pop_req_o,
    output logic [SEL_W-1:0]      pop_sel_o,
    output logic                  read_o,
    output logic [SEL_W-1:0]      disp_o,
    output logic [DATA_W-1:0]     data_o,
    output logic [7:0]            read_cnt_o
);

    // One counter serves both the interval wait and the show phase.
    localparam int CNT_MAX = (READ_INTERVAL > SHOW_CYCLES) ? READ_INTERVAL : SHOW_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RI_LAST = CNT_W'(READ_INTERVAL - 1);
    localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [SEL_W-1:0]    rr_ptr_q;
    logic                pop_req_q;
    logic [SEL_W-1:0]    pop_sel_q;
    logic                read_q;
    logic [SEL_W-1:0]    disp_q;
    logic [DATA_W-1:0]   data_q;
    logic [7:0]          read_cnt_q;

    logic [OCC_BUS_W-1:0] occ_sat;
    logic                 sel_valid;
    logic [SEL_W-1:0]     sel_idx;
    logic [DATA_W-1:0]    head_sel;

    for (genvar b = 0; b < NUM_BUF; b++) begin : g_sat
        assign occ_sat[b*OCC_W +: OCC_W] = sat_occ(occ_i[b*OCC_W +: OCC_W], DEPTH_C);
    end

    rr_max_select u_sel (
        .occ_i    (occ_sat),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (sel_valid),
        .idx_o    (sel_idx)
    );

    // Payload of the buffer currently being popped (sel is held in POP).
    assign head_sel = head_data_i[pop_sel_q*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            pop_req_q  <= 1'b0;
            pop_sel_q  <= '0;
            read_q     <= 1'b0;
            disp_q     <= '0;
            data_q     <= '0;
            read_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (start) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!start) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == RI_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_SELECT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SELECT: begin
                    // All buffers empty: skip this interval.
                    if (sel_valid) begin
                        pop_sel_q <= sel_idx;
                        pop_req_q <= 1'b1;
                        state_q   <= ST_POP;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_POP: begin
                    // start is deliberately ignored: the handshake must finish.
                    if (pop_ack_i) begin
                        pop_req_q  <= 1'b0;
                        data_q     <= head_sel;
                        disp_q     <= pop_sel_q;
                        read_cnt_q <= read_cnt_q + 8'd1;
                        rr_ptr_q   <= pop_sel_q + SEL_W'(1);
                        read_q     <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SC_LAST) begin
                        read_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= start ? ST_WAIT : ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pop_req_o  = pop_req_q;
    assign pop_sel_o  = pop_sel_q;
    assign read_o     = read_q;
    assign disp_o     = disp_q;
    assign data_o     = data_q;
    assign read_cnt_o = read_cnt_q;

endmodule

// File: tb/tb_buffer_read_scheduler.sv
// Scoreboard bench: each phase pushes the expected pops (buffer, payload);
// a responder/monitor acks requests after a programmable hold and checks
// each completed pop against the queue head.
module tb_buffer_read_scheduler;

    localparam int RI = 8;
    localparam int SC = 4;

    typedef struct packed {
        logic [1:0] sel;
        logic [1:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] occ_i = '0;
    logic [7:0]  head_data_i = '0;
    logic        pop_ack_i;
    logic        pop_req_o;
    logic [1:0]  pop_sel_o;
    logic        read_o;
    logic [1:0]  disp_o;
    logic [1:0]  data_o;
    logic [7:0]  read_cnt_o;

    int   errors = 0;
    int   checks = 0;
    int   ack_hold = 1;
    int   exp_cnt = 0;
    exp_t sb_q[$];

    buffer_read_scheduler #(
        .READ_INTERVAL (RI),
        .SHOW_CYCLES   (SC),
        .DEPTH         (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .occ_i       (occ_i),
        .head_data_i (head_data_i),
        .pop_ack_i   (pop_ack_i),
        .pop_req_o   (pop_req_o),
        .pop_sel_o   (pop_sel_o),
        .read_o      (read_o),
        .disp_o      (disp_o),
        .data_o      (data_o),
        .read_cnt_o  (read_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] occ4(input int b0, input int b1, input int b2, input int b3);
        return {3'(b3), 3'(b2), 3'(b1), 3'(b0)};
    endfunction

    function automatic logic [1:0] head_of(input logic [7:0] hd, input int b);
        return hd[2*b +: 2];
    endfunction

    task automatic push_exp(input int b);
        exp_t e;
        e.sel  = 2'(b);
        e.data = head_of(head_data_i, b);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb_q.size(), 0);
        start = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_req(input int bound);
        int n = 0;
        while (!pop_req_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", int'(pop_req_o), 1);
    endtask

    // Responder + monitor: ack after ack_hold request cycles, then score.
    initial begin
        int   req_cnt;
        int   n;
        logic [1:0] sel_first;
        exp_t e;
        pop_ack_i = 1'b0;
        req_cnt   = 0;
        sel_first = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pop_ack_i = 1'b0;
                req_cnt   = 0;
                exp_cnt   = 0;
            end else if (pop_req_o) begin
                if (req_cnt == 0) sel_first = pop_sel_o;
                else chk("sel_stable", int'(pop_sel_o), int'(sel_first));
                pop_ack_i = (req_cnt == ack_hold - 1);
                req_cnt++;
                if (pop_ack_i) begin
                    @(posedge clk);
                    #1;
                    pop_ack_i = 1'b0;
                    exp_cnt++;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_pop", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("pop_sel", int'(sel_first), int'(e.sel));
                        chk("disp", int'(disp_o), int'(e.sel));
                        chk("data", int'(data_o), int'(e.data));
                    end
                    chk("read_cnt", int'(read_cnt_o), exp_cnt % 256);
                    chk("req_len", req_cnt, ack_hold);
                    chk("req_fall", int'(pop_req_o), 0);
                    chk("read_rise", int'(read_o), 1);
                    n = 0;
                    forever begin
                        @(negedge clk);
                        if (read_o && n < 50) n++;
                        else break;
                    end
                    chk("show_len", n, SC);
                    req_cnt = 0;
                end
            end else begin
                pop_ack_i = 1'b0;
                req_cnt   = 0;
            end
        end
    end

    initial begin
        int n;
        int cnt_snap;

        // Reset state
        #1;
        chk("rst0_req", int'(pop_req_o), 0);
        chk("rst0_read", int'(read_o), 0);
        chk("rst0_cnt", int'(read_cnt_o), 0);
        do_reset();

        // All empty: no pops over 100 cycles
        occ_i = occ4(0, 0, 0, 0);
        start = 1'b1;
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (pop_req_o) n++;
        end
        chk("empty_no_req", n, 0);
        chk("empty_cnt", int'(read_cnt_o), 0);

        // Max selection and tie-break advance: {2,5,1,5} -> 1 then 3
        ack_hold    = 1;
        head_data_i = 8'b11_00_01_10;
        occ_i       = occ4(2, 5, 1, 5);
        push_exp(1);
        push_exp(3);
        wait_drain(200);

        // All full, immediate ack: order 0,1,2,3,0
        do_reset();
        head_data_i = 8'b11_10_01_00;
        occ_i       = occ4(6, 6, 6, 6);
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        start = 1'b1;
        wait_drain(400);
        chk("full_cnt5", int'(read_cnt_o), 5);

        // Delayed ack; occupancy change mid-POP must not move pop_sel_o
        ack_hold    = 7;
        head_data_i = 8'b00_10_00_00;
        occ_i       = occ4(0, 0, 3, 0);
        push_exp(2);
        start = 1'b1;
        wait_req(100);
        repeat (2) @(negedge clk);
        occ_i = occ4(0, 0, 0, 5);
        wait_drain(200);

        // Drop start during POP: handshake completes, then idle
        ack_hold    = 5;
        head_data_i = 8'b00_00_01_00;
        occ_i       = occ4(0, 4, 0, 0);
        push_exp(1);
        start = 1'b1;
        wait_req(100);
        start = 1'b0;
        wait_drain(200);
        cnt_snap = int'(read_cnt_o);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (pop_req_o) n++;
        end
        chk("idle_no_req", n, 0);
        chk("idle_cnt", int'(read_cnt_o), cnt_snap);

        // Reset mid-POP: outputs clear asynchronously
        ack_hold = 1000;
        occ_i    = occ4(0, 0, 0, 2);
        start    = 1'b1;
        wait_req(100);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", int'(pop_req_o), 0);
        chk("arst_sel", int'(pop_sel_o), 0);
        chk("arst_read", int'(read_o), 0);
        chk("arst_disp", int'(disp_o), 0);
        chk("arst_data", int'(data_o), 0);
        chk("arst_cnt", int'(read_cnt_o), 0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ack_hold = 1;

        // Field value 7 saturates to 6: ties with others, 0 then 1
        head_data_i = 8'b00_01_10_11;
        occ_i       = occ4(7, 6, 6, 6);
        push_exp(0);
        push_exp(1);
        start = 1'b1;
        wait_drain(200);
        chk("sat_cnt", int'(read_cnt_o), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/buffer_read_scheduler.md
# buffer_read_scheduler

Paced read scheduler for the four packet buffers filled by the key-entry front end. Once per read interval it picks one non-empty buffer, the fullest, with round-robin tie-break, so drops are minimised. It then pops that buffer's head packet through a request/acknowledge handshake and presents the packet and buffer id for the LED/VGA status logic. It sits between the buffer storage and the drain/display path and is the only block that issues pops.

## Interface
- `READ_INTERVAL`, 150000000: cycles between selection attempts (3 s at 50 MHz); ≥2.
- `SHOW_CYCLES`, 25000000: cycles `read_o` stays high after a completed pop; ≥1.
- `DEPTH`, 6: slots per buffer; occupancy inputs above DEPTH saturate to DEPTH.
- `clk`  in  1  system clock (CLOCK_50 domain).
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level enable; scheduling runs only while high.
- `occ_i`  in  12  four 3-bit occupancy counts; buffer b at [3b+2:3b].
- `head_data_i`  in  8  four 2-bit head-packet payloads; buffer b at [2b+1:2b].
- `pop_ack_i`  in  1  buffer side has removed the head of `pop_sel_o`.
- `pop_req_o`  out  1  pop request, held until acknowledged.
- `pop_sel_o`  out  2  buffer being popped; stable while `pop_req_o`=1.
- `read_o`  out  1  read-activity indicator.
- `disp_o`  out  2  id of last buffer read.
- `data_o`  out  2  payload of last packet read.
- `read_cnt_o`  out  8  completed pops, wraps 255→0.

## Operation
- States: IDLE, WAIT, SELECT, POP, SHOW.
- IDLE: counter cleared. When `start`=1, go to WAIT.
- WAIT: the interval counter increments each cycle. At count READ_INTERVAL-1, go to SELECT. If `start`=0, return to IDLE.
- SELECT (1 cycle): compute maxocc = max of the saturated occupancies.
  - If maxocc=0: no pop; go to WAIT with the counter cleared.
  - Otherwise: choose the first buffer with occupancy==maxocc, scanning upward from `rr_ptr` modulo 4. Register it into `pop_sel_o` and go to POP.
- POP: `pop_req_o`=1 with `pop_sel_o` held. `start` is ignored here; the handshake always completes.
  - On the cycle `pop_ack_i`=1: capture `data_o` ← head_data_i[sel] and `disp_o` ← sel.
  - In the same cycle: increment `read_cnt_o`, set `rr_ptr` ← sel+1 (mod 4), and go to SHOW.
- SHOW: `read_o`=1 for exactly SHOW_CYCLES cycles, then go to WAIT, or to IDLE if `start`=0.
- `pop_ack_i` outside POP is ignored.
- Occupancy changes during POP do not alter `pop_sel_o`.
- Reset values: state IDLE, all outputs 0, `rr_ptr`=0, counters 0. Reset mid-handshake drops `pop_req_o` immediately; no capture occurs.

## Timing
- `pop_req_o` rises the cycle after SELECT, i.e. READ_INTERVAL+1 cycles after entering WAIT.
- Zero-latency ack: if `pop_ack_i` is high in the first POP cycle, `pop_req_o` is high for exactly 1 cycle.
- `data_o`, `disp_o` and `read_cnt_o` update on the clock edge that samples the ack.
- `read_o` rises that same edge and falls SHOW_CYCLES edges later.
- `pop_req_o` falls on the ack edge, so there is never a second request without re-selection.
- Minimum period between pops: READ_INTERVAL + 1 + 1 + SHOW_CYCLES cycles.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package holds: the state encoding; constants NUM_BUF=4, OCC_W=3, DATA_W=2; slot-field helper constants used by the buffer and display logic.
- One sub-module, `rr_max_select`: a combinational argmax over four 3-bit occupancies with round-robin tie-break from `rr_ptr`. It outputs a valid flag and a 2-bit index. The FSM, counters and capture registers stay in the top.

## Test plan
Use READ_INTERVAL=8, SHOW_CYCLES=4.
- Reset then `start`=1 with occ={0,0,0,0}: `pop_req_o` never asserts over 100 cycles; `read_cnt_o`=0.
- occ b0..b3={2,5,1,5}, rr_ptr=0: selects buffer 1. Hold occupancies; the next selection is buffer 3 (tie-break advances).
- occ={6,6,6,6}, immediate ack every time: pop order 0,1,2,3,0. `read_cnt_o` reaches 5. `read_o` high 4 cycles per pop.
- Ack delayed 7 cycles, head_data_i[b2]=2'b10, occ={0,0,3,0}: `pop_req_o` high 7 cycles with `pop_sel_o`=2. Then `disp_o`=2, `data_o`=2'b10.
- Drop `start` during POP: the handshake completes, then SHOW, then IDLE. Assert `rst_n`=0 mid-POP: all outputs 0 asynchronously.
- occ_i field value 7 on buffer 0 with others at 6: treated as 6; tie resolved from rr_ptr.
